// File: rtl/mac_scheduler.sv
// mac_scheduler
//   Round-robin scheduler that shares one DW-bit multiply-accumulate datapath
//   between NREQ AXI-stream requesters. A requester is granted for a whole job
//   (a run of i/k operand pairs ended by tlast). The bias is taken from the
//   first beat. The result is b + sum(i*k), computed modulo 2^DW with each
//   product truncated to DW bits. It is returned with the requester index.
//
//   Optional feature macro: MAC_SCHED_TIMEOUT_EN
//     When defined, a job that accepts no beat for TIMEOUT consecutive RUN
//     cycles is closed early. Its partial sum is returned with o_terr=1.
//
// Handshake rule, used by every port pair here (s_* and o_*): a transfer
// happens on a rising clk edge where valid and ready are both 1. Once valid is
// raised, the payload is held until that edge. Ready never waits on anything
// but state.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   s_tvalid   [NREQ]       per-requester beat valid
//   s_tready   [NREQ]       per-requester beat ready (only the granted one)
//   s_tlast    [NREQ]       last beat of the job
//   s_i_tdata  [NREQ*DW]    operand i, requester n at [n*DW +: DW]
//   s_k_tdata  [NREQ*DW]    operand k, same packing
//   s_b_tdata  [NREQ*DW]    bias, used on the first beat only
//   o_tvalid / o_tready     result handshake
//   o_tdata    [DW]         result
//   o_tid      [clog2 NREQ] requester index of the result
//   o_terr                  job closed by timeout
//   busy                    scheduler not idle
module mac_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         s_tvalid,
    output logic [NREQ-1:0]         s_tready,
    input  logic [NREQ-1:0]         s_tlast,
    input  logic [NREQ*DW-1:0]      s_i_tdata,
    input  logic [NREQ*DW-1:0]      s_k_tdata,
    input  logic [NREQ*DW-1:0]      s_b_tdata,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [DW-1:0]           o_tdata,
    output logic [$clog2(NREQ)-1:0] o_tid,
    output logic                    o_terr,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] g;
    logic [IW-1:0] last_grant;
    logic [DW-1:0] acc;
    logic [DW-1:0] prod;
    logic          prod_vld;
    logic          first_beat;
    logic          err;

`ifdef MAC_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
`endif

    // Round-robin pick: first valid requester after last_grant, wrapping.
    logic [IW-1:0] winner;
    logic          found;
    int            idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last_grant) + off) % NREQ;
            if (!found && s_tvalid[idx]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    // Payload of the granted lane.
    logic [DW-1:0] beat_i;
    logic [DW-1:0] beat_k;
    logic [DW-1:0] beat_b;
    logic          beat;
    logic          beat_last;
    logic [DW-1:0] mul_lo;

    assign beat_i    = s_i_tdata[int'(g)*DW +: DW];
    assign beat_k    = s_k_tdata[int'(g)*DW +: DW];
    assign beat_b    = s_b_tdata[int'(g)*DW +: DW];
    assign beat      = (state == ST_RUN) && s_tvalid[g];
    assign beat_last = s_tlast[g];
    // DW-wide context keeps only the low DW bits of the product.
    assign mul_lo    = beat_i * beat_k;

    always_comb begin
        s_tready = '0;
        if (state == ST_RUN) begin
            s_tready[g] = 1'b1;
        end
    end

    // Result outputs are driven only in OUT so they read zero everywhere else.
    assign o_tvalid = (state == ST_OUT);
    assign o_tdata  = (state == ST_OUT) ? acc : '0;
    assign o_tid    = (state == ST_OUT) ? g : '0;
    assign o_terr   = (state == ST_OUT) ? err : 1'b0;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            g          <= '0;
            last_grant <= IW'(NREQ - 1);
            acc        <= '0;
            prod       <= '0;
            prod_vld   <= 1'b0;
            first_beat <= 1'b0;
            err        <= 1'b0;
`ifdef MAC_SCHED_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        g          <= winner;
                        acc        <= '0;
                        prod_vld   <= 1'b0;
                        first_beat <= 1'b1;
                        err        <= 1'b0;
`ifdef MAC_SCHED_TIMEOUT_EN
                        idle_cnt   <= '0;
`endif
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        // The product is one stage behind the beat. It is
                        // folded in on the next beat or in DRAIN.
                        prod       <= mul_lo;
                        prod_vld   <= 1'b1;
                        first_beat <= 1'b0;
                        if (first_beat) begin
                            acc <= beat_b;
                        end else if (prod_vld) begin
                            acc <= acc + prod;
                        end
                        if (beat_last) begin
                            state <= ST_DRAIN;
                        end
`ifdef MAC_SCHED_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
`ifdef MAC_SCHED_TIMEOUT_EN
                    else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_DRAIN;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (prod_vld) begin
                        acc <= acc + prod;
                    end
                    prod_vld <= 1'b0;
                    state    <= ST_OUT;
                end
                default: begin
                    if (o_tready) begin
                        last_grant <= g;
                        err        <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
// tb_mac_scheduler
//   Bench for mac_scheduler. Each job's expected result is b + sum(i*k)
//   mod 2^DW. The expected output order comes from a round-robin pick over the
//   requesters that still hold jobs.
module tb_mac_scheduler;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;
    localparam int IW      = $clog2(NREQ);
    localparam int EW      = 1 + IW + DW;
    localparam int BW      = 3 * DW + 1;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     s_tvalid = '0;
    logic [NREQ-1:0]     s_tready;
    logic [NREQ-1:0]     s_tlast = '0;
    logic [NREQ*DW-1:0]  s_i_tdata = '0;
    logic [NREQ*DW-1:0]  s_k_tdata = '0;
    logic [NREQ*DW-1:0]  s_b_tdata = '0;
    logic                o_tvalid;
    logic                o_tready = 1'b1;
    logic [DW-1:0]       o_tdata;
    logic [IW-1:0]       o_tid;
    logic                o_terr;
    logic                busy;

    int checks = 0;
    int errors = 0;

    // Per-requester beats {last, b, k, i}, per-requester job results, and the
    // expected output stream {err, tid, data}.
    logic [BW-1:0] beat_q [NREQ][$];
    logic [DW-1:0] job_res [NREQ][$];
    logic [EW-1:0] exp_q[$];
    int            acc_run [NREQ];
    bit            first_run [NREQ];
    int            lg_model;

    mac_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .s_i_tdata (s_i_tdata),
        .s_k_tdata (s_k_tdata),
        .s_b_tdata (s_b_tdata),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .o_tdata   (o_tdata),
        .o_tid     (o_tid),
        .o_terr    (o_terr),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required end of tests");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    task automatic clear_model();
        for (int n = 0; n < NREQ; n++) begin
            beat_q[n].delete();
            job_res[n].delete();
            acc_run[n]   = 0;
            first_run[n] = 1'b1;
        end
        exp_q.delete();
        lg_model = NREQ - 1;
    endtask

    task automatic add_beat(input int n, input int i, input int k, input int b, input bit last);
        beat_q[n].push_back({last, DW'(b), DW'(k), DW'(i)});
        if (first_run[n]) acc_run[n] = (b + i * k) % 256;
        else              acc_run[n] = (acc_run[n] + (i * k) % 256) % 256;
        first_run[n] = last;
        if (last) job_res[n].push_back(DW'(acc_run[n]));
    endtask

    // Serve queued jobs in rotation order starting after the last grant.
    task automatic predict();
        int total;
        int n;
        total = 0;
        for (int r = 0; r < NREQ; r++) total += job_res[r].size();
        for (int j = 0; j < total; j++) begin
            for (int off = 1; off <= NREQ; off++) begin
                n = (lg_model + off) % NREQ;
                if (job_res[n].size() > 0) begin
                    exp_q.push_back({1'b0, IW'(n), job_res[n].pop_front()});
                    lg_model = n;
                    break;
                end
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0);
        for (int n = 0; n < NREQ; n++) if (beat_q[n].size() != 0) p = 1'b1;
        return p;
    endfunction

    // ---------------- drivers ----------------
    task automatic present(input int n);
        logic [BW-1:0] bt;
        if (beat_q[n].size() > 0) begin
            bt = beat_q[n][0];
            s_tvalid[n] = 1'b1;
            s_tlast[n]  = bt[3*DW];
            s_i_tdata[n*DW +: DW] = bt[DW-1:0];
            s_k_tdata[n*DW +: DW] = bt[2*DW-1:DW];
            s_b_tdata[n*DW +: DW] = bt[3*DW-1:2*DW];
        end else begin
            s_tvalid[n] = 1'b0;
            s_tlast[n]  = 1'b0;
        end
    endtask

    task automatic drive_lane(input int n, input int i, input int k, input int b, input bit last);
        s_tvalid[n] = 1'b1;
        s_tlast[n]  = last;
        s_i_tdata[n*DW +: DW] = DW'(i);
        s_k_tdata[n*DW +: DW] = DW'(k);
        s_b_tdata[n*DW +: DW] = DW'(b);
    endtask

    // Present one beat on lane n and hold it until accepted (bounded).
    task automatic send_beat(input int n, input int i, input int k, input int b, input bit last);
        int w;
        drive_lane(n, i, k, b, last);
        w = 0;
        @(negedge clk);
        while (!s_tready[n] && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!s_tready[n]) begin
            errors++;
            $display("FAIL beat_accept lane %0d: s_tready=%b, required lane ready within 40 cycles", n, s_tready);
        end
        @(posedge clk); #1;
        s_tvalid[n] = 1'b0;
        s_tlast[n]  = 1'b0;
    endtask

    // Drive all queued beats, optionally with in-job gaps and random o_tready,
    // and score every output transfer against exp_q.
    task automatic run_jobs(input int budget, input bit rnd);
        int            gap [NREQ];
        logic [NREQ-1:0] hs;
        logic [BW-1:0] bt;
        logic [EW-1:0] obs;
        logic [EW-1:0] prev;
        logic [EW-1:0] exp;
        bit            held;
        int            cyc;
        held = 1'b0;
        prev = '0;
        for (int n = 0; n < NREQ; n++) begin
            gap[n] = 0;
            present(n);
        end
        o_tready = 1'b1;
        cyc = 0;
        while (pending() && cyc < budget) begin
            @(negedge clk);
            hs  = s_tvalid & s_tready;
            obs = {o_terr, o_tid, o_tdata};
            if (held) begin
                checks++;
                if (!o_tvalid || obs !== prev) begin
                    errors++;
                    $display("FAIL out_stable: got valid=%b {err,tid,data}=%h, required valid=1 %h", o_tvalid, obs, prev);
                end
            end
            if (o_tvalid && o_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got {err,tid,data}=%h, required no result", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL result: got {err,tid,data}=%h, required %h", obs, exp);
                    end
                end
            end
            held = o_tvalid && !o_tready;
            prev = obs;
            @(posedge clk); #1;
            for (int n = 0; n < NREQ; n++) begin
                if (hs[n]) begin
                    bt = beat_q[n][0];
                    void'(beat_q[n].pop_front());
                    gap[n] = (rnd && !bt[3*DW]) ? int'($urandom_range(0, 2)) : 0;
                end
                if (gap[n] > 0) begin
                    s_tvalid[n] = 1'b0;
                    gap[n]--;
                end else begin
                    present(n);
                end
            end
            o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL run_budget: %0d results still outstanding after %0d cycles, required 0", exp_q.size(), budget);
        end
        s_tvalid = '0;
        s_tlast  = '0;
        o_tready = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        o_tready = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b0;
        s_tvalid = '1;
        clear_model();
        @(negedge clk);
        checks++;
        if (s_tready !== '0) begin errors++; $display("FAIL reset_s_tready: got %b, required 0", s_tready); end
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_o_tvalid: got %b, required 0", o_tvalid); end
        checks++;
        if (o_tdata !== '0) begin errors++; $display("FAIL reset_o_tdata: got %h, required 0", o_tdata); end
        checks++;
        if (o_tid !== '0) begin errors++; $display("FAIL reset_o_tid: got %0d, required 0", o_tid); end
        checks++;
        if (o_terr !== 1'b0) begin errors++; $display("FAIL reset_o_terr: got %b, required 0", o_terr); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        s_tvalid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single-beat job on lane 1 from idle: grant at +1, result at +3, bubble after.
    task automatic test_latency();
        drive_lane(1, 5, 7, 3, 1'b1);
        @(negedge clk);
        checks++;
        if (s_tready !== '0 || o_tvalid !== 1'b0) begin
            errors++; $display("FAIL lat_cycle0: got s_tready=%b o_tvalid=%b, required 0000/0", s_tready, o_tvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_tready !== 4'b0010) begin errors++; $display("FAIL lat_grant: got s_tready=%b, required 0010", s_tready); end
        @(posedge clk); #1;
        s_tvalid[1] = 1'b0;
        s_tlast[1]  = 1'b0;
        @(negedge clk);
        checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b1 || s_tready !== '0) begin
            errors++; $display("FAIL lat_drain: got o_tvalid=%b busy=%b s_tready=%b, required 0/1/0000", o_tvalid, busy, s_tready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 8'd38 || o_tid !== 2'd1 || o_terr !== 1'b0) begin
            errors++; $display("FAIL lat_out: got valid=%b data=%0d tid=%0d err=%b, required 1/38/1/0", o_tvalid, o_tdata, o_tid, o_terr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++; $display("FAIL lat_bubble: got busy=%b o_tvalid=%b, required 0/0", busy, o_tvalid);
        end
        @(posedge clk); #1;
        lg_model = 1;
    endtask

    task automatic test_basic();
        add_beat(0, 2, 3, 1, 1'b0);
        add_beat(0, 4, 5, 77, 1'b1);
        predict();
        run_jobs(100, 1'b0);
    endtask

    task automatic test_rotation();
        do_reset();
        for (int n = 0; n < NREQ; n++) add_beat(n, 1, 1, n, 1'b1);
        predict();
        run_jobs(200, 1'b0);
        add_beat(1, 6, 6, 0, 1'b1);
        predict();
        run_jobs(100, 1'b0);
        add_beat(0, 3, 4, 10, 1'b1);
        add_beat(2, 5, 5, 20, 1'b1);
        predict();
        run_jobs(100, 1'b0);
    endtask

    task automatic test_wrap();
        add_beat(2, 16, 16, 2, 1'b0);
        add_beat(2, 15, 17, 200, 1'b1);
        predict();
        run_jobs(100, 1'b0);
    endtask

    task automatic test_backpressure();
        int w;
        o_tready = 1'b0;
        send_beat(3, 9, 9, 5, 1'b1);
        w = 0;
        @(negedge clk);
        while (!o_tvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!o_tvalid) begin errors++; $display("FAIL bp_wait: got o_tvalid=0, required result within 20 cycles"); end
        @(posedge clk); #1;
        drive_lane(0, 1, 1, 1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== 8'd86 || o_tid !== 2'd3 || s_tready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b data=%0d tid=%0d s_tready=%b busy=%b, required 1/86/3/0000/1",
                         o_tvalid, o_tdata, o_tid, s_tready, busy);
            end
            @(posedge clk); #1;
        end
        s_tvalid[0] = 1'b0;
        s_tlast[0]  = 1'b0;
        o_tready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got busy=%b o_tvalid=%b, required 0/0", busy, o_tvalid);
        end
        @(posedge clk); #1;
        lg_model = 3;
    endtask

    task automatic test_reset_mid();
        send_beat(0, 2, 2, 1, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== '0 || o_tdata !== '0 || o_tid !== '0 || o_terr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b s_tready=%b data=%h tid=%0d err=%b, required all 0",
                     o_tvalid, busy, s_tready, o_tdata, o_tid, o_terr);
        end
        clear_model();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        add_beat(3, 7, 3, 4, 1'b1);
        add_beat(0, 1, 2, 3, 1'b0);
        add_beat(0, 4, 4, 9, 1'b0);
        add_beat(0, 10, 30, 9, 1'b1);
        predict();
        run_jobs(200, 1'b0);
    endtask

    task automatic test_timeout();
        int w;
        send_beat(1, 3, 3, 0, 1'b0);
`ifdef MAC_SCHED_TIMEOUT_EN
        w = 0;
        @(negedge clk);
        while (!o_tvalid && w < 30) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 8'd9 || o_tid !== 2'd1 || o_terr !== 1'b1) begin
            errors++; $display("FAIL timeout_result: got valid=%b data=%0d tid=%0d err=%b, required 1/9/1/1", o_tvalid, o_tdata, o_tid, o_terr);
        end
        checks++;
        if (w < 15 || w > 19) begin
            errors++; $display("FAIL timeout_delay: got %0d cycles, required 15..19", w);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_terr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: got err=%b busy=%b, required 0/0", o_terr, busy);
        end
        @(posedge clk); #1;
`else
        repeat (20) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b1 || s_tready !== 4'b0010) begin
            errors++; $display("FAIL hold_grant: got valid=%b busy=%b s_tready=%b, required 0/1/0010", o_tvalid, busy, s_tready);
        end
        @(posedge clk); #1;
        send_beat(1, 1, 1, 50, 1'b1);
        w = 0;
        @(negedge clk);
        while (!o_tvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 8'd10 || o_tid !== 2'd1 || o_terr !== 1'b0) begin
            errors++; $display("FAIL late_beat: got valid=%b data=%0d tid=%0d err=%b, required 1/10/1/0", o_tvalid, o_tdata, o_tid, o_terr);
        end
        @(posedge clk); #1;
`endif
        lg_model = 1;
    endtask

    task automatic test_random();
        int nj;
        int nb;
        int b;
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < NREQ; n++) begin
                nj = $urandom_range(0, 2);
                for (int j = 0; j < nj; j++) begin
                    nb = $urandom_range(1, 4);
                    b  = $urandom_range(0, 255);
                    for (int t = 0; t < nb; t++) begin
                        add_beat(n, $urandom_range(0, 255), $urandom_range(0, 255),
                                 (t == 0) ? b : int'($urandom_range(0, 255)), t == nb - 1);
                    end
                end
            end
            predict();
            run_jobs(3000, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_rotation();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
